// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags
// and sticky overflow/underflow indicators.
module sfifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] din,
    input  logic             r_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);

    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_THRESH < 1 || AF_THRESH > DEPTH - 1 ||
        AE_THRESH < 0 || AE_THRESH >= AF_THRESH) begin : g_param_check
        $fatal(1, "sfifo_param: illegal parameter combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt_nxt;
    logic             rd_ok, wr_ok;

    // Writing into a full FIFO is legal when the same edge frees a slot.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    always_comb begin
        cnt_nxt = count;
        if (wr_ok && !rd_ok)      cnt_nxt = count + 1'b1;
        else if (rd_ok && !wr_ok) cnt_nxt = count - 1'b1;
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            count        <= cnt_nxt;
            full         <= (cnt_nxt == FULL_CNT);
            empty        <= (cnt_nxt == '0);
            almost_full  <= (cnt_nxt >= AF_CNT);
            almost_empty <= (cnt_nxt <= AE_CNT);
            // A new error on the clearing edge must not be lost.
            overflow     <= (overflow  & ~err_clr) | (w_en & ~wr_ok);
            underflow    <= (underflow & ~err_clr) | (r_en & empty);
        end
    end
endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param at WIDTH=8, DEPTH=64, AF=56, AE=8.
module tb_sfifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [6:0] count;

    int checks = 0;
    int errors = 0;

    sfifo_param #(.WIDTH(8), .DEPTH(64), .AF_THRESH(56), .AE_THRESH(8)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " empty"}, int'(empty), 1);
        chk({tag, " almost_empty"}, int'(almost_empty), 1);
        chk({tag, " full"}, int'(full), 0);
        chk({tag, " almost_full"}, int'(almost_full), 0);
        chk({tag, " count"}, int'(count), 0);
        chk({tag, " dout"}, int'(dout), 0);
        chk({tag, " overflow"}, int'(overflow), 0);
        chk({tag, " underflow"}, int'(underflow), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset
        repeat (4) tick();
        chk_reset_state("rst");
        rst = 1'b1;
        tick();
        chk_reset_state("idle");

        // 2: fill 100..163
        for (int i = 0; i < 64; i++) begin
            w_en = 1'b1; din = 8'(100 + i);
            tick();
            chk("fill count", int'(count), i + 1);
            chk("fill ae", int'(almost_empty), (i + 1 <= 8) ? 1 : 0);
            chk("fill af", int'(almost_full), (i + 1 >= 56) ? 1 : 0);
            chk("fill full", int'(full), (i == 63) ? 1 : 0);
            chk("fill ovf", int'(overflow), 0);
        end

        // 3: overflow then clear
        din = 8'd200;
        tick();
        w_en = 1'b0;
        chk("ovf set", int'(overflow), 1);
        chk("ovf count", int'(count), 64);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf clr", int'(overflow), 0);

        // 4: simultaneous read/write at full
        for (int i = 0; i < 36; i++) begin
            w_en = 1'b1; r_en = 1'b1; din = 8'(164 + i);
            tick();
            chk("rw dout", int'(dout), 100 + i);
            chk("rw count", int'(count), 64);
            chk("rw full", int'(full), 1);
            chk("rw ovf", int'(overflow), 0);
        end
        w_en = 1'b0;

        // 5: drain 136..199
        for (int i = 0; i < 64; i++) begin
            r_en = 1'b1;
            tick();
            chk("drain dout", int'(dout), 136 + i);
            chk("drain count", int'(count), 63 - i);
        end
        chk("drain empty", int'(empty), 1);
        chk("drain udf", int'(underflow), 0);
        tick();
        r_en = 1'b0;
        chk("udf set", int'(underflow), 1);
        chk("udf dout", int'(dout), 199);
        chk("udf count", int'(count), 0);
        // set and clear on the same edge: set wins
        r_en = 1'b1; err_clr = 1'b1;
        tick();
        r_en = 1'b0;
        chk("udf set wins", int'(underflow), 1);
        tick();
        err_clr = 1'b0;
        chk("udf clr", int'(underflow), 0);

        // empty with w_en & r_en: write only, no bypass
        w_en = 1'b1; r_en = 1'b1; din = 8'h33;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("e_rw count", int'(count), 1);
        chk("e_rw udf", int'(underflow), 1);
        chk("e_rw dout", int'(dout), 199);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("e_rw read", int'(dout), 8'h33);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // 6: async reset mid-stream
        for (int i = 0; i < 20; i++) begin
            w_en = 1'b1; din = 8'(i + 1);
            tick();
        end
        w_en = 1'b0;
        chk("pre rst count", int'(count), 20);
        #2 rst = 1'b0;
        #1;
        chk_reset_state("async");
        rst = 1'b1;
        tick();
        w_en = 1'b1; din = 8'h5A;
        tick();
        w_en = 1'b0; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("post rst dout", int'(dout), 8'h5A);
        chk("post rst empty", int'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
